// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle unsigned restoring divider with start/busy/done handshake.
// Defining DIV_BY_ZERO_FLAG_EN adds a sticky div_by_zero port and a one-cycle zero-divisor bypass.
module sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
`ifdef DIV_BY_ZERO_FLAG_EN
  output logic             div_by_zero,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] r, q, dvs, q_nxt, r_nxt;
  logic [WIDTH:0]   t, diff;
  logic [CW-1:0]    cnt;
  logic             ge, accept, zero;
  always_comb begin
    t      = {r, q[WIDTH-1]};
    diff   = t - {1'b0, dvs};
    ge     = t >= {1'b0, dvs};
    r_nxt  = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    q_nxt  = {q[WIDTH-2:0], ge};
    accept = start && state != RUN;
  end
`ifdef DIV_BY_ZERO_FLAG_EN
  assign zero = divisor == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) div_by_zero <= 1'b0;
    else if (accept) div_by_zero <= zero;
`else
  assign zero = 1'b0;
`endif
  assign busy = state == RUN;
  assign done = state == DONE;
  // r stays below the divisor, so its top bit is always zero and only WIDTH bits are kept
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept && zero) begin
      state     <= DONE;
      quotient  <= '1;
      remainder <= dividend;
    end else if (accept) begin
      state <= RUN;
      r     <= '0;
      q     <= dividend;
      dvs   <= divisor;
      cnt   <= CW'(WIDTH);
    end else if (state == RUN) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state     <= DONE;
        quotient  <= q_nxt;
        remainder <= r_nxt;
      end
    end else if (state == DONE) state <= IDLE;
endmodule
